rf_sequencer: RTL and testbench
===============================

# rf_sequencer

Command-driven access sequencer for the 8×16 register file: it accepts one ALU-style command at a time over a valid/ready handshake. For each command it:
- drives the register file read ports and captures both operands,
- computes a 16-bit result and writes it back through the write port,
- returns the result on a valid/ready response channel.

It is the initiator side of the register-file port set, sitting between a command source (test harness or future control unit) and the register file.

## Interface
Parameters: none (data width 16, address width 3, fixed).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  3  operation code
- cmd_dst  in  3  destination register
- cmd_src0  in  3  operand A register
- cmd_src1  in  3  operand B register
- cmd_imm  in  16  immediate (LDI only)
- rf_rd0_addr  out  3  to register file read port 0
- rf_rd1_addr  out  3  to register file read port 1
- rf_rd0_data  in  16  combinational read data, port 0
- rf_rd1_data  in  16  combinational read data, port 1
- rf_wr_en  out  1  register file write enable
- rf_wr_addr  out  3  register file write address
- rf_wr_data  out  16  register file write data
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  16  result of completed command
- cmd_count  out  16  number of completed commands

## Operation
- Op codes (all arithmetic modulo 2^16, no flags):
  - 0 ADD: A+B
  - 1 SUB: A−B
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 LDI: result = imm
  - 6 RD: result = A, no write
  - 7 NOT: result = ~A
- FSM states: IDLE, READ, WRITE, RESP.
  - IDLE: cmd_ready=1. On cmd_valid=1, latch op/dst/src0/src1/imm and go to READ.
  - READ: rf_rd0_addr=latched src0, rf_rd1_addr=latched src1. Capture rf_rd0_data/rf_rd1_data into operand registers A/B at the closing edge. Go to WRITE.
  - WRITE: compute result from A/B/imm and latch it into the result register at the closing edge.
    - rf_wr_en=1, rf_wr_addr=dst, rf_wr_data=result for all ops except RD.
    - For RD, rf_wr_en=0.
    - Go to RESP.
  - RESP: rsp_valid=1, rsp_data=result register. On rsp_ready=1, increment cmd_count and go to IDLE.
- cmd_ready=0 in READ, WRITE and RESP. No command is accepted while a command is in flight.
- Read-port addresses hold the latched src values outside READ (don't-care for the register file). rf_wr_addr/rf_wr_data also hold their values, but rf_wr_en is 1 only in WRITE.
- cmd_count wraps 0xFFFF→0x0000.
- dst equal to src0/src1 is legal. Operands are captured in READ before the write in WRITE, so the old value is used.
- cmd_* inputs are ignored outside IDLE. Changing them after acceptance has no effect.

## Timing
- Acceptance at edge E0 (IDLE, cmd_valid=1).
  - READ during cycle E0→E1.
  - WRITE during E1→E2; the register file updates at E2.
  - rsp_valid=1 from E2.
- Minimum issue interval is 4 cycles when rsp_ready is held 1. cmd_ready returns to 1 the cycle after the response handshake.
- rsp_valid and rsp_data stay stable while rsp_ready=0, for an unbounded number of cycles.
- Reset values, applied immediately on rst rising:
  - state=IDLE, so cmd_ready=1
  - rf_wr_en=0, rsp_valid=0, rsp_data=0, cmd_count=0
  - latched command/operand registers = 0
  - rf_rd0_addr=rf_rd1_addr=rf_wr_addr=0, rf_wr_data=0
- No command is accepted on any edge while rst=1.
- Reset mid-operation discards the in-flight command. If rst asserts during WRITE, rf_wr_en drops asynchronously. Whether that edge's write lands is a register-file concern: the register file's own reset also clears it.

## Test plan
- Reset, then LDI dst=3 imm=0x1234 → rf_wr_en=1 for exactly one cycle with addr 3, data 0x1234; rsp_data=0x1234 two cycles after acceptance; cmd_count=1.
- LDI r1=0xFFFF, LDI r2=0x0001, ADD dst=4 src0=1 src1=2 → writes 0x0000 (wrap). Then SUB dst=5 src0=2 src1=1 → 0x0002.
- LDI r6=0x00F0, then XOR dst=6 src0=6 src1=6 (dst=src) → 0x0000 written, operands read as 0x00F0. Then RD src0=6 → rsp_data=0x0000 with rf_wr_en never asserted.
- Hold rsp_ready=0 for 10 cycles after rsp_valid → rsp_valid/rsp_data stable, cmd_ready=0, and a second cmd_valid is not accepted. Then rsp_ready=1 → cmd_ready=1 the next cycle, cmd_count incremented once.
- Back-to-back commands with cmd_valid and rsp_ready held 1 → accepts every 4 cycles; after 3 commands cmd_count=3.
- Assert rst during WRITE of ADD → rf_wr_en=0, rsp_valid=0 and cmd_count=0 immediately. After release, cmd_ready=1 and the next command completes normally.

Source files
------------

// File: rtl/rf_sequencer_if.sv
// Port bundle between the rf_sequencer and its environment: command channel,
// register-file read/write ports, response channel and completion counter.
interface rf_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [2:0]  cmd_dst;
    logic [2:0]  cmd_src0;
    logic [2:0]  cmd_src1;
    logic [15:0] cmd_imm;
    logic [2:0]  rf_rd0_addr;
    logic [2:0]  rf_rd1_addr;
    logic [15:0] rf_rd0_data;
    logic [15:0] rf_rd1_data;
    logic        rf_wr_en;
    logic [2:0]  rf_wr_addr;
    logic [15:0] rf_wr_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [15:0] cmd_count;

    // Environment side: command source, register file and response consumer.
    modport master (
        output cmd_valid, cmd_op, cmd_dst, cmd_src0, cmd_src1, cmd_imm,
        output rf_rd0_data, rf_rd1_data, rsp_ready,
        input  cmd_ready, rf_rd0_addr, rf_rd1_addr, rf_wr_en, rf_wr_addr,
        input  rf_wr_data, rsp_valid, rsp_data, cmd_count
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_dst, cmd_src0, cmd_src1, cmd_imm,
        input  rf_rd0_data, rf_rd1_data, rsp_ready,
        output cmd_ready, rf_rd0_addr, rf_rd1_addr, rf_wr_en, rf_wr_addr,
        output rf_wr_data, rsp_valid, rsp_data, cmd_count
    );
endinterface

// File: rtl/rf_sequencer.sv
// Sequences one ALU command at a time through the 8x16 register file:
// read both operands, write the result back, then hand it out on the response channel.
module rf_sequencer (
    input  logic          clk,
    input  logic          rst,
    rf_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDI = 3'd5;
    localparam logic [2:0] OP_RD  = 3'd6;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d, dst_q, dst_d, src0_q, src0_d, src1_q, src1_d;
    logic [15:0] imm_q, imm_d, a_q, a_d, b_q, b_d, res_q, res_d, cnt_q, cnt_d;
    logic [15:0] alu_result;

    function automatic logic [15:0] alu_f(input logic [2:0]  op,
                                          input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic [15:0] imm);
        case (op)
            OP_ADD:  alu_f = a + b;
            OP_SUB:  alu_f = a - b;
            OP_AND:  alu_f = a & b;
            OP_OR:   alu_f = a | b;
            OP_XOR:  alu_f = a ^ b;
            OP_LDI:  alu_f = imm;
            OP_RD:   alu_f = a;
            default: alu_f = ~a;
        endcase
    endfunction

    assign alu_result = alu_f(op_q, a_q, b_q, imm_q);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        dst_d   = dst_q;
        src0_d  = src0_q;
        src1_d  = src1_q;
        imm_d   = imm_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    op_d    = bus.cmd_op;
                    dst_d   = bus.cmd_dst;
                    src0_d  = bus.cmd_src0;
                    src1_d  = bus.cmd_src1;
                    imm_d   = bus.cmd_imm;
                    state_d = READ;
                end
            end
            READ: begin
                a_d     = bus.rf_rd0_data;
                b_d     = bus.rf_rd1_data;
                state_d = WRITE;
            end
            WRITE: begin
                res_d   = alu_result;
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    cnt_d   = cnt_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            dst_q   <= '0;
            src0_q  <= '0;
            src1_q  <= '0;
            imm_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dst_q   <= dst_d;
            src0_q  <= src0_d;
            src1_q  <= src1_d;
            imm_q   <= imm_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.cmd_ready   = (state_q == IDLE);
    assign bus.rf_rd0_addr = src0_q;
    assign bus.rf_rd1_addr = src1_q;
    assign bus.rf_wr_addr  = dst_q;
    // Write data is the live ALU output during WRITE so the file sees it at the
    // same edge the result register captures it; afterwards it holds that value.
    assign bus.rf_wr_data  = (state_q == WRITE) ? alu_result : res_q;
    assign bus.rf_wr_en    = (state_q == WRITE) && (op_q != OP_RD);
    assign bus.rsp_valid   = (state_q == RESP);
    assign bus.rsp_data    = res_q;
    assign bus.cmd_count   = cnt_q;
endmodule

// File: tb/tb_rf_sequencer.sv
// Bench for rf_sequencer: table of directed commands, hand-built stall/back-to-back/
// reset sequences, then random commands checked against an array model of the register file.
module tb_rf_sequencer;
    logic clk = 1'b0;
    logic rst;

    rf_sequencer_if bus ();

    rf_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Register file with combinational reads, cleared by its own reset.
    logic [15:0] rf_mem [8];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) rf_mem[i] <= '0;
        end else if (bus.rf_wr_en) begin
            rf_mem[bus.rf_wr_addr] <= bus.rf_wr_data;
        end
    end
    assign bus.rf_rd0_data = rf_mem[bus.rf_rd0_addr];
    assign bus.rf_rd1_data = rf_mem[bus.rf_rd1_addr];

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  dst;
        logic [2:0]  s0;
        logic [2:0]  s1;
        logic [15:0] imm;
        logic [15:0] exp;
    } vec_t;

    int total = 0;
    int bad   = 0;

    int unsigned m_rf [8];
    int unsigned exp_count = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic int unsigned model_result(input int op, input int s0, input int s1,
                                                 input int unsigned imm);
        int unsigned a = m_rf[s0];
        int unsigned b = m_rf[s1];
        case (op)
            0:       return (a + b) % 65536;
            1:       return (a + 65536 - b) % 65536;
            2:       return a & b;
            3:       return a | b;
            4:       return a ^ b;
            5:       return imm;
            6:       return a;
            default: return 65535 - a;
        endcase
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 8; i++) m_rf[i] = 0;
        exp_count = 0;
    endtask

    // Starts and ends on a falling edge with the sequencer idle; rsp_ready held 1.
    task automatic do_cmd(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] s0,
                          input logic [2:0] s1, input logic [15:0] imm, input logic [15:0] exp,
                          input string name);
        chk({name, ".idle_ready"}, 16'(bus.cmd_ready), 16'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_dst   = dst;
        bus.cmd_src0  = s0;
        bus.cmd_src1  = s1;
        bus.cmd_imm   = imm;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk({name, ".read_ready"}, 16'(bus.cmd_ready), 16'd0);
        chk({name, ".read_wr_en"}, 16'(bus.rf_wr_en), 16'd0);
        bus.cmd_op   = 3'($urandom);
        bus.cmd_dst  = 3'($urandom);
        bus.cmd_src0 = 3'($urandom);
        bus.cmd_src1 = 3'($urandom);
        bus.cmd_imm  = 16'($urandom);
        @(negedge clk);
        chk({name, ".write_wr_en"}, 16'(bus.rf_wr_en), (op != 3'd6) ? 16'd1 : 16'd0);
        if (op != 3'd6) begin
            chk({name, ".wr_addr"}, 16'(bus.rf_wr_addr), 16'(dst));
            chk({name, ".wr_data"}, bus.rf_wr_data, exp);
        end
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk({name, ".rsp_valid"}, 16'(bus.rsp_valid), 16'd1);
        chk({name, ".rsp_data"}, bus.rsp_data, exp);
        chk({name, ".resp_wr_en"}, 16'(bus.rf_wr_en), 16'd0);
        if (op != 3'd6) m_rf[dst] = exp;
        exp_count = (exp_count + 1) % 65536;
        @(negedge clk);
        chk({name, ".count"}, bus.cmd_count, 16'(exp_count));
        chk({name, ".rf_dst"}, rf_mem[dst], 16'(m_rf[dst]));
    endtask

    vec_t tbl [13];
    int   acc_q [$];

    initial begin
        tbl[0]  = '{3'd5, 3'd3, 3'd0, 3'd0, 16'h1234, 16'h1234};
        tbl[1]  = '{3'd5, 3'd1, 3'd0, 3'd0, 16'hFFFF, 16'hFFFF};
        tbl[2]  = '{3'd5, 3'd2, 3'd0, 3'd0, 16'h0001, 16'h0001};
        tbl[3]  = '{3'd0, 3'd4, 3'd1, 3'd2, 16'h0000, 16'h0000};
        tbl[4]  = '{3'd1, 3'd5, 3'd2, 3'd1, 16'h0000, 16'h0002};
        tbl[5]  = '{3'd5, 3'd6, 3'd0, 3'd0, 16'h00F0, 16'h00F0};
        tbl[6]  = '{3'd4, 3'd6, 3'd6, 3'd6, 16'h0000, 16'h0000};
        tbl[7]  = '{3'd6, 3'd0, 3'd6, 3'd0, 16'h0000, 16'h0000};
        tbl[8]  = '{3'd3, 3'd7, 3'd1, 3'd3, 16'h0000, 16'hFFFF};
        tbl[9]  = '{3'd2, 3'd0, 3'd3, 3'd1, 16'h0000, 16'h1234};
        tbl[10] = '{3'd7, 3'd2, 3'd3, 3'd0, 16'h0000, 16'hEDCB};
        tbl[11] = '{3'd1, 3'd4, 3'd2, 3'd1, 16'h0000, 16'hEDCC};
        tbl[12] = '{3'd0, 3'd4, 3'd4, 3'd4, 16'h0000, 16'hDB98};

        rst           = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd5;
        bus.cmd_dst   = 3'd1;
        bus.cmd_src0  = 3'd2;
        bus.cmd_src1  = 3'd3;
        bus.cmd_imm   = 16'hBEEF;
        bus.rsp_ready = 1'b0;
        clear_model();
        repeat (3) @(negedge clk);

        // Reset state, with a command offered that must not be taken
        chk("rst.cmd_ready", 16'(bus.cmd_ready), 16'd1);
        chk("rst.wr_en", 16'(bus.rf_wr_en), 16'd0);
        chk("rst.rsp_valid", 16'(bus.rsp_valid), 16'd0);
        chk("rst.rsp_data", bus.rsp_data, 16'd0);
        chk("rst.count", bus.cmd_count, 16'd0);
        chk("rst.rd0_addr", 16'(bus.rf_rd0_addr), 16'd0);
        chk("rst.rd1_addr", 16'(bus.rf_rd1_addr), 16'd0);
        chk("rst.wr_addr", 16'(bus.rf_wr_addr), 16'd0);
        chk("rst.wr_data", bus.rf_wr_data, 16'd0);
        bus.cmd_valid = 1'b0;
        rst           = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++)
            do_cmd(tbl[i].op, tbl[i].dst, tbl[i].s0, tbl[i].s1, tbl[i].imm, tbl[i].exp,
                   $sformatf("tbl%0d", i));

        // Response stall: result held, second command refused
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd5;
        bus.cmd_dst   = 3'd5;
        bus.cmd_imm   = 16'hA5A5;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        bus.cmd_dst   = 3'd7;
        bus.cmd_imm   = 16'h7777;
        repeat (2) @(negedge clk);
        chk("stall.rsp_valid0", 16'(bus.rsp_valid), 16'd1);
        chk("stall.rsp_data0", bus.rsp_data, 16'hA5A5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall.rsp_valid", 16'(bus.rsp_valid), 16'd1);
            chk("stall.rsp_data", bus.rsp_data, 16'hA5A5);
            chk("stall.cmd_ready", 16'(bus.cmd_ready), 16'd0);
            chk("stall.count", bus.cmd_count, 16'(exp_count));
        end
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b0;
        m_rf[5]       = 16'hA5A5;
        exp_count     = (exp_count + 1) % 65536;
        @(negedge clk);
        chk("stall.ready_after", 16'(bus.cmd_ready), 16'd1);
        chk("stall.count_after", bus.cmd_count, 16'(exp_count));
        chk("stall.rf5", rf_mem[5], 16'(m_rf[5]));
        chk("stall.rf7_untouched", rf_mem[7], 16'(m_rf[7]));

        // Back-to-back: valid and ready held high
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd5;
        bus.cmd_dst   = 3'd1;
        bus.cmd_imm   = 16'h0BB0;
        bus.rsp_ready = 1'b1;
        acc_q.delete();
        for (int i = 0; i < 12; i++) begin
            if (bus.cmd_ready) acc_q.push_back(i);
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        chk("b2b.accepts", 16'(acc_q.size()), 16'd3);
        if (acc_q.size() == 3) begin
            chk("b2b.first", 16'(acc_q[0]), 16'd0);
            chk("b2b.gap1", 16'(acc_q[1] - acc_q[0]), 16'd4);
            chk("b2b.gap2", 16'(acc_q[2] - acc_q[1]), 16'd4);
        end
        m_rf[1]   = 16'h0BB0;
        exp_count = (exp_count + 3) % 65536;
        chk("b2b.count", bus.cmd_count, 16'(exp_count));
        chk("b2b.rf1", rf_mem[1], 16'(m_rf[1]));

        // Reset asserted during the WRITE cycle of an ADD
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd0;
        bus.cmd_dst   = 3'd4;
        bus.cmd_src0  = 3'd1;
        bus.cmd_src1  = 3'd2;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("rstw.wr_en_before", 16'(bus.rf_wr_en), 16'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstw.wr_en", 16'(bus.rf_wr_en), 16'd0);
        chk("rstw.rsp_valid", 16'(bus.rsp_valid), 16'd0);
        chk("rstw.count", bus.cmd_count, 16'd0);
        chk("rstw.cmd_ready", 16'(bus.cmd_ready), 16'd1);
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        do_cmd(3'd5, 3'd2, 3'd0, 3'd0, 16'h5555, 16'h5555, "post_rst_ldi");
        do_cmd(3'd0, 3'd3, 3'd2, 3'd2, 16'h0000, 16'hAAAA, "post_rst_add");

        // Random commands against the array model
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op, dst, s0, s1;
            logic [15:0] imm, exp;
            op  = 3'($urandom);
            dst = 3'($urandom);
            s0  = 3'($urandom);
            s1  = 3'($urandom);
            imm = 16'($urandom);
            exp = 16'(model_result(int'(op), int'(s0), int'(s1), int'(imm)));
            do_cmd(op, dst, s0, s1, imm, exp, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
